// File: rtl/dmux8way16_stream.sv
`default_nettype none
// ============================================================================
// Module   : dmux8way16_stream
// Purpose  : Registered 1-to-8 demultiplexer for WIDTH-bit words. One word
//            per cycle is accepted on a valid/ready input and steered by
//            `sel` into one of eight single-entry output buffers. Each
//            buffer has its own valid/ready handshake.
// Ports    : clk            system clock (rising edge)
//            reset          synchronous, active-high reset
//            bcast          broadcast request (only with DMUX8_BROADCAST_EN)
//            in[WIDTH]      input word
//            sel[3]         destination channel (0=a .. 7=h)
//            in_valid       input word present
//            in_ready       addressed channel(s) can take a word this cycle
//            out_data[8*W]  packed channel data, channel k at [k*W +: W]
//            out_valid[8]   per-channel buffer full
//            out_ready[8]   per-channel consumer accepts the word
// Options  : `define DMUX8_BROADCAST_EN adds the `bcast` input; a broadcast
//            push loads `in` into all eight buffers at once.
// Revision : 1.0  initial release
// ============================================================================
module dmux8way16_stream #(
    parameter int WIDTH     = 16,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
`ifdef DMUX8_BROADCAST_EN
    input  logic               bcast,
`endif
    input  logic [WIDTH-1:0]   in,
    input  logic [2:0]         sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready
);

    // Channel state encoding (one 2-state machine per channel).
    localparam logic c_EMPTY = 1'b0;
    localparam logic c_FULL  = 1'b1;

    logic [7:0] w_full;       // current state of each channel
    logic [7:0] w_slot_free;  // channel can take a word at the next edge
    logic [7:0] w_sel_onehot;
    logic [7:0] w_push;       // channel is loaded at the next edge
    logic [7:0] w_pop;        // channel is drained at the next edge
    logic       w_accept;

    // A full slot is still free this cycle if its consumer drains it, which
    // gives back-to-back reload with no bubble.
    assign w_slot_free  = ~w_full | out_ready;
    assign w_sel_onehot = 8'b0000_0001 << sel;

`ifdef DMUX8_BROADCAST_EN
    // Broadcast must land in every buffer atomically, so all eight slots
    // have to be free; sel is ignored.
    assign in_ready = bcast ? (&w_slot_free) : w_slot_free[sel];
    assign w_accept = in_valid && in_ready;
    assign w_push   = bcast ? {8{w_accept}} : ({8{w_accept}} & w_sel_onehot);
`else
    assign in_ready = w_slot_free[sel];
    assign w_accept = in_valid && in_ready;
    assign w_push   = {8{w_accept}} & w_sel_onehot;
`endif

    // out_ready on an empty channel is ignored.
    assign w_pop     = w_full & out_ready;
    assign out_valid = w_full;

    for (genvar k = 0; k < 8; k++) begin : g_chan
        logic             r_state;
        logic [WIDTH-1:0] r_data;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_EMPTY;
                r_data  <= '0;
            end else if (w_push[k]) begin
                // Push wins over a simultaneous pop: the old word leaves and
                // the new one takes its place in the same edge.
                r_state <= c_FULL;
                r_data  <= in;
            end else if (w_pop[k]) begin
                r_state <= c_EMPTY;
            end
        end

        assign w_full[k] = (r_state == c_FULL);

        if (ZERO_IDLE) begin : g_zero_idle
            // Empty channels read as zero, matching combinational DMux output.
            assign out_data[k*WIDTH +: WIDTH] = w_full[k] ? r_data : '0;
        end else begin : g_hold_idle
            assign out_data[k*WIDTH +: WIDTH] = r_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmux8way16_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmux8way16_stream
// Purpose  : Self-checking bench for dmux8way16_stream. Directed scenarios
//            with literal expectations, then randomized traffic compared on
//            every cycle against a behavioural channel model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmux8way16_stream;

    localparam int WIDTH = 16;
    localparam bit ZI    = 1'b1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [WIDTH-1:0]   in = '0;
    logic [2:0]         sel = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready = '0;
    logic               bcast = 1'b0;

    int tests = 0;
    int fails = 0;

    dmux8way16_stream #(.WIDTH(WIDTH), .ZERO_IDLE(ZI)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef DMUX8_BROADCAST_EN
        .bcast     (bcast),
`endif
        .in        (in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Each channel is a one-word mailbox: occupied flag plus stored word.
    bit              m_occ  [8];
    logic [WIDTH-1:0] m_word [8];
    bit              m_live = 1'b0;

    function automatic bit exp_ready();
        bit ok;
        ok = 1'b1;
`ifdef DMUX8_BROADCAST_EN
        if (bcast) begin
            for (int k = 0; k < 8; k++)
                if (m_occ[k] && !out_ready[k]) ok = 1'b0;
            return ok;
        end
`endif
        return !m_occ[sel] || out_ready[sel];
    endfunction

    always @(posedge clk) begin
        bit acc;
        acc = in_valid && exp_ready();
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                m_occ[k]  = 1'b0;
                m_word[k] = '0;
            end
            m_live = 1'b1;
        end else begin
            // Consumers take their words first; then the accepted input lands.
            for (int k = 0; k < 8; k++)
                if (m_occ[k] && out_ready[k]) m_occ[k] = 1'b0;
            if (acc) begin
                for (int k = 0; k < 8; k++) begin
                    if (bcast || (sel == 3'(k))) begin
                        m_occ[k]  = 1'b1;
                        m_word[k] = in;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [8*WIDTH-1:0] act,
                       input logic [8*WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        logic [7:0]         ev;
        logic [8*WIDTH-1:0] ed;
        if (m_live && !reset) begin
            for (int k = 0; k < 8; k++) begin
                ev[k] = m_occ[k];
                ed[k*WIDTH +: WIDTH] = (ZI && !m_occ[k]) ? '0 : m_word[k];
            end
            chk("model out_valid", {120'd0, out_valid}, {120'd0, ev});
            chk("model out_data", out_data, ed);
            chk("model in_ready", {127'd0, in_ready}, {127'd0, exp_ready()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ch(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    initial begin
        logic [8*WIDTH-1:0] exp_d;

        // Reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset out_valid", {120'd0, out_valid}, 128'd0);
        chk("reset out_data", out_data, 128'd0);

        // 1: single word to channel 5
        in = 16'h1234; sel = 3'd5; in_valid = 1'b1; out_ready = 8'hFF;
        @(negedge clk);
        chk("t1 in_ready", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1 out_valid", {120'd0, out_valid}, 128'h20);
        exp_d = '0;
        exp_d[5*WIDTH +: WIDTH] = 16'h1234;
        chk("t1 out_data", out_data, exp_d);
        tick();

        // 2: stall on full channel 2, then reload with no bubble
        out_ready = 8'h00;
        in = 16'hAAAA; sel = 3'd2; in_valid = 1'b1;
        tick();
        in = 16'hBBBB;
        @(negedge clk);
        chk("t2 stall in_ready", {127'd0, in_ready}, 128'd0);
        chk("t2 hold data", {112'd0, ch(2)}, {112'd0, 16'hAAAA});
        tick();
        @(negedge clk);
        chk("t2 still held", {112'd0, ch(2)}, {112'd0, 16'hAAAA});
        out_ready = 8'h04;
        @(negedge clk);
        chk("t2 ready on pop", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0; out_ready = 8'h00;
        @(negedge clk);
        chk("t2 valid kept", {127'd0, out_valid[2]}, 128'd1);
        chk("t2 reload data", {112'd0, ch(2)}, {112'd0, 16'hBBBB});
        out_ready = 8'h04;
        tick();
        out_ready = 8'h00;

        // 3: stalled channel 3, switch sel to free channel 6
        in = 16'h3333; sel = 3'd3; in_valid = 1'b1;
        tick();
        in = 16'h0033;
        @(negedge clk);
        chk("t3 stall", {127'd0, in_ready}, 128'd0);
        tick();
        in = 16'h00C6; sel = 3'd6;
        @(negedge clk);
        chk("t3 free ch6", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3 out_valid", {120'd0, out_valid}, 128'h48);
        chk("t3 ch3", {112'd0, ch(3)}, {112'd0, 16'h3333});
        chk("t3 ch6", {112'd0, ch(6)}, {112'd0, 16'h00C6});
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;

        // 4: fill all eight, then drain in one edge
        for (int i = 0; i < 8; i++) begin
            in = 16'(i); sel = 3'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4 all full", {120'd0, out_valid}, 128'hFF);
        exp_d = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
        chk("t4 data", out_data, exp_d);
        out_ready = 8'hFF;
        tick();
        @(negedge clk);
        chk("t4 drained", {120'd0, out_valid}, 128'd0);
        out_ready = 8'h00;

        // 5: push during reset is discarded
        in = 16'hFFFF; sel = 3'd0; in_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5 out_valid", {120'd0, out_valid}, 128'd0);
        chk("t5 out_data", out_data, 128'd0);
        chk("t5 in_ready", {127'd0, in_ready}, 128'd1);

`ifdef DMUX8_BROADCAST_EN
        // 6: broadcast into empty buffers, then blocked by channel 4
        bcast = 1'b1; in = 16'h5A5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; bcast = 1'b0;
        @(negedge clk);
        chk("t6 all valid", {120'd0, out_valid}, 128'hFF);
        chk("t6 data", out_data, {8{16'h5A5A}});
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
        in = 16'h4444; sel = 3'd4; in_valid = 1'b1;
        tick();
        bcast = 1'b1; in = 16'h1111;
        @(negedge clk);
        chk("t6 bcast blocked", {127'd0, in_ready}, 128'd0);
        tick();
        bcast = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t6 unchanged valid", {120'd0, out_valid}, 128'h10);
        chk("t6 unchanged ch4", {112'd0, ch(4)}, {112'd0, 16'h4444});
        out_ready = 8'hFF;
        tick();
`endif

        // Randomized traffic, checked by the compare process each cycle
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            in        = WIDTH'($urandom);
            sel       = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       out_ready = 8'h00;
                1:       out_ready = 8'hFF;
                default: out_ready = 8'($urandom);
            endcase
`ifdef DMUX8_BROADCAST_EN
            bcast = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; bcast = 1'b0;
        tick();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
